// File: rtl/rv_dmem_responder.sv
// Data-memory responder: target end of the split address/data D-memory handshake.
// Each access is latched, acknowledged, and later answered with a Data_rsp pulse.
module rv_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Address_vld,
  input  logic [31:0] MemAddress_i,
  input  logic        MemOp,
  input  logic [1:0]  MemOpSize,
  output logic        Address_rsp,
  input  logic        WData_vld,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        Data_rsp,
  output logic        Mem_err
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_WDATA,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        op_q, op_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        addr_rsp_q, addr_rsp_d;
  logic        data_rsp_q, data_rsp_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic [31:0]   offset;
  logic [31:0]   word_idx;
  logic [AW-1:0] widx;
  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          wr_en;

  // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    word_idx = {2'b00, offset[31:2]};
    widx     = word_idx[AW-1:0];
    acc_err  = (size_q == 2'b01 && addr_q[0])
            || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
            || (size_q == 2'b11)
            || (word_idx >= DEPTH_WORDS);
  end

  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Address_vld) begin
          addr_d  = MemAddress_i;
          op_d    = MemOp;
          size_d  = MemOpSize;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (op_q)                 state_d = S_WDATA;
        else if (WAIT_CYCLES > 0) state_d = S_WAIT;
        else                      state_d = S_RESP;
      end
      S_WDATA: begin
        if (WData_vld) begin
          wdata_d = WriteData_i;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    addr_rsp_d = (state_d == S_ACK);
    data_rsp_d = (state_d == S_RESP);
    err_d      = data_rsp_d && acc_err;
    rdata_d    = (data_rsp_d && !op_q && !acc_err) ? mem[widx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      op_q       <= 1'b0;
      size_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      addr_rsp_q <= 1'b0;
      data_rsp_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      addr_rsp_q <= addr_rsp_d;
      data_rsp_q <= data_rsp_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign wr_en = (state_q == S_RESP) && op_q && !err_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign Address_rsp = addr_rsp_q;
  assign Data_rsp    = data_rsp_q;
  assign Mem_err     = err_q;
  assign ReadData_o  = rdata_q;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Scoreboarded bench for rv_dmem_responder: one instance with no wait states at base 0,
// one with three wait states at base 0x1000, sharing a stimulus bus steered by sel.
module tb_rv_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        Address_vld = 1'b0;
  logic [31:0] MemAddress_i = '0;
  logic        MemOp = 1'b0;
  logic [1:0]  MemOpSize = '0;
  logic        WData_vld = 1'b0;
  logic [31:0] WriteData_i = '0;

  logic        a_arsp, a_drsp, a_err, b_arsp, b_drsp, b_err;
  logic [31:0] a_rd, b_rd;
  logic        arsp, drsp, merr;
  logic [31:0] rdata;

  assign arsp  = sel ? b_arsp : a_arsp;
  assign drsp  = sel ? b_drsp : a_drsp;
  assign merr  = sel ? b_err  : a_err;
  assign rdata = sel ? b_rd   : a_rd;

  always #5 clk = ~clk;

  rv_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .Address_vld(Address_vld & ~sel), .MemAddress_i(MemAddress_i), .MemOp(MemOp),
    .MemOpSize(MemOpSize), .Address_rsp(a_arsp),
    .WData_vld(WData_vld & ~sel), .WriteData_i(WriteData_i),
    .ReadData_o(a_rd), .Data_rsp(a_drsp), .Mem_err(a_err)
  );

  rv_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .Address_vld(Address_vld & sel), .MemAddress_i(MemAddress_i), .MemOp(MemOp),
    .MemOpSize(MemOpSize), .Address_rsp(b_arsp),
    .WData_vld(WData_vld & sel), .WriteData_i(WriteData_i),
    .ReadData_o(b_rd), .Data_rsp(b_drsp), .Mem_err(b_err)
  );

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_drsp || b_drsp) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_rsp: got Data_rsp with no access pending");
      end else begin
        mon_e = sb.pop_front();
        chk("mem_err", {31'b0, merr}, {31'b0, mon_e.err});
        if (mon_e.chk_rd) chk("read_data", rdata, mon_e.rd);
      end
    end
  end

  // late > 0 raises WData_vld that many cycles after Address_rsp is seen.
  task automatic access(input logic op, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int late, input logic exp_err,
                        input logic [31:0] exp_rd, input string name);
    int   n, arsp_cyc, drsp_cyc, arsp_cnt, wc, exp_lat;
    exp_t e;
    wc = sel ? 3 : 0;
    e.err = exp_err;
    e.chk_rd = !op;
    e.rd = exp_rd;
    sb.push_back(e);
    Address_vld  = 1'b1;
    MemAddress_i = a;
    MemOp        = op;
    MemOpSize    = sz;
    WriteData_i  = wd;
    WData_vld    = op && (late == 0);
    n = 0;
    arsp_cyc = -1;
    drsp_cyc = -1;
    arsp_cnt = 0;
    while (drsp_cyc < 0 && n < 60) begin
      @(negedge clk);
      if (arsp) begin
        arsp_cnt++;
        arsp_cyc = n;
      end
      if (drsp) drsp_cyc = n;
      @(posedge clk);
      #1;
      n++;
      if (arsp_cyc >= 0) Address_vld = 1'b0;
      if (op && late > 0 && arsp_cyc >= 0 && n == arsp_cyc + late) WData_vld = 1'b1;
    end
    WData_vld   = 1'b0;
    Address_vld = 1'b0;
    if (drsp_cyc < 0 && sb.size() > 0) void'(sb.pop_back());
    exp_lat = op ? (((late > 0) ? 2 + late : 3) + wc) : 2 + wc;
    chk({name, " addr_rsp_count"}, arsp_cnt, 1);
    chk({name, " addr_rsp_cycle"}, arsp_cyc, 1);
    chk({name, " data_rsp_cycle"}, drsp_cyc, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drsp_seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_rdata", a_rd, 32'h0);
    chk("reset_a_flags", {29'b0, a_arsp, a_drsp, a_err}, 32'h0);
    chk("reset_b_rdata", b_rd, 32'h0);
    chk("reset_b_flags", {29'b0, b_arsp, b_drsp, b_err}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    access(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0, "wr_word");
    access(1'b0, 2'b10, 32'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF, "rd_word");

    access(1'b1, 2'b10, 32'h20, 32'h0000_0000, 0, 1'b0, 32'h0, "wr_zero_20");
    access(1'b1, 2'b00, 32'h22, 32'hFFFF_FFAB, 0, 1'b0, 32'h0, "wr_byte_22");
    access(1'b1, 2'b01, 32'h20, 32'hFFFF_1234, 0, 1'b0, 32'h0, "wr_half_20");
    access(1'b0, 2'b10, 32'h20, 32'h0, 0, 1'b0, 32'h00AB_1234, "rd_lanes");
    access(1'b0, 2'b00, 32'h23, 32'h0, 0, 1'b0, 32'h00AB_1234, "rd_byte_fullword");
    access(1'b1, 2'b00, 32'h21, 32'h0000_00CD, 0, 1'b0, 32'h0, "wr_byte_21");
    access(1'b1, 2'b01, 32'h22, 32'hAAAA_5678, 0, 1'b0, 32'h0, "wr_half_22");
    access(1'b0, 2'b10, 32'h20, 32'h0, 0, 1'b0, 32'h5678_CD34, "rd_lanes2");

    access(1'b1, 2'b10, 32'h30, 32'h5566_7788, 0, 1'b0, 32'h0, "wr_word_30");
    access(1'b1, 2'b01, 32'h31, 32'hFFFF_9999, 0, 1'b1, 32'h0, "wr_half_misaligned");
    access(1'b0, 2'b10, 32'h32, 32'h0, 0, 1'b1, 32'h0, "rd_word_misaligned");
    access(1'b1, 2'b11, 32'h30, 32'h0, 0, 1'b1, 32'h0, "wr_reserved_size");
    access(1'b0, 2'b11, 32'h30, 32'h0, 0, 1'b1, 32'h0, "rd_reserved_size");
    access(1'b0, 2'b10, 32'h30, 32'h0, 0, 1'b0, 32'h5566_7788, "rd_unchanged_30");

    access(1'b0, 2'b10, 32'h1000, 32'h0, 0, 1'b1, 32'h0, "rd_out_of_range");
    access(1'b1, 2'b10, 32'h1000, 32'h7777_7777, 0, 1'b1, 32'h0, "wr_out_of_range");
    access(1'b0, 2'b10, 32'h0, 32'h0, 0, 1'b0, 32'h0, "rd_word0_untouched");
    access(1'b1, 2'b10, 32'hFFC, 32'h0BAD_F00D, 0, 1'b0, 32'h0, "wr_last_word");
    access(1'b0, 2'b10, 32'hFFC, 32'h0, 0, 1'b0, 32'h0BAD_F00D, "rd_last_word");

    access(1'b1, 2'b10, 32'h44, 32'hCAFE_F00D, 4, 1'b0, 32'h0, "wr_late_data");
    access(1'b0, 2'b10, 32'h44, 32'h0, 0, 1'b0, 32'hCAFE_F00D, "rd_after_late");

    sel = 1'b1;
    @(posedge clk);
    #1;
    access(1'b1, 2'b10, 32'h1010, 32'hDEADBEEF, 0, 1'b0, 32'h0, "b_wr_word");
    access(1'b0, 2'b10, 32'h1010, 32'h0, 0, 1'b0, 32'hDEADBEEF, "b_rd_word");
    access(1'b0, 2'b10, 32'h0FFC, 32'h0, 0, 1'b1, 32'h0, "b_rd_below_base");
    access(1'b1, 2'b10, 32'h1040, 32'h1111_2222, 0, 1'b0, 32'h0, "b_wr_1040");

    // Write to 0x1040 aborted by reset while the wait counter is running.
    Address_vld  = 1'b1;
    MemAddress_i = 32'h1040;
    MemOp        = 1'b1;
    MemOpSize    = 2'b10;
    WriteData_i  = 32'hFFFF_FFFF;
    WData_vld    = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    Address_vld = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_rdata", b_rd, 32'h0);
    chk("reset_mid_flags", {29'b0, b_arsp, b_drsp, b_err}, 32'h0);
    drsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_drsp) drsp_seen++;
    end
    chk("reset_mid_no_data_rsp", drsp_seen, 0);
    WData_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, 2'b10, 32'h1040, 32'h0, 0, 1'b0, 32'h1111_2222, "b_rd_after_reset");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
